control_funcion_conf: RTL
=========================

CONTROL_FUNCION_CONF -- requirements
Module: control_funcion_conf

Interface
REQ-001 SHALL have parameter TIMEOUT_CYC, default 500_000_000, meaning inactivity cycles before a configuration mode auto-exits (5 s at 100 MHz).
REQ-002 SHALL have port clk, input, 1, system clock; the only clock; all state changes on its rising edge.
REQ-003 SHALL have port reset, input, 1, asynchronous, active-high reset.
REQ-004 SHALL have port btn_hora, input, 1, debounced level for "configure time of day".
REQ-005 SHALL have port btn_fecha, input, 1, debounced level for "configure date".
REQ-006 SHALL have port btn_timer, input, 1, debounced level for "configure countdown timer".
REQ-007 SHALL have port btn_ok, input, 1, debounced level for "confirm/commit".
REQ-008 SHALL have port btn_salir, input, 1, debounced level for "exit without commit / cancel countdown".
REQ-009 SHALL have port fin_timer, input, 1, level, high while the countdown value is zero.
REQ-010 SHALL have port funcion_conf, output, 3, registered mode code feeding the register chip-select decoder.
REQ-011 SHALL have port flag_mostrar_count, output, 1, registered; high while the countdown runs.
REQ-012 SHALL have port pulso_guardar, output, 1, registered one-cycle commit strobe.

Function
REQ-013 SHALL detect a button event as a rising edge, i.e. the input high and its one-cycle registered copy low; only events act.
REQ-014 SHALL implement four states with funcion_conf equal to the state code: IDLE=000, CONF_HORA=001, CONF_FECHA=010, CONF_TIMER=100; no other code SHALL ever be output.
REQ-015 SHALL, in IDLE, move on a btn_hora/btn_fecha/btn_timer event to CONF_HORA/CONF_FECHA/CONF_TIMER; simultaneous events SHALL resolve with priority hora > fecha > timer.
REQ-016 SHALL, in any CONF state, ignore mode-button events for transitions; they SHALL still count as activity (REQ-019).
REQ-017 SHALL, in any CONF state, return to IDLE on a btn_ok or btn_salir event; btn_salir SHALL win if both occur in the same cycle.
REQ-018 SHALL assert pulso_guardar for exactly one cycle, coincident with the return to IDLE, on a btn_ok exit from CONF_HORA or CONF_FECHA only.
REQ-019 SHALL run a 29-bit inactivity counter in CONF states only; it SHALL clear on entering a CONF state and on any button event; on reaching TIMEOUT_CYC-1 the FSM SHALL return to IDLE next edge with no pulso_guardar and no flag change; the counter SHALL hold 0 in IDLE.
REQ-020 SHALL set flag_mostrar_count on a btn_ok exit from CONF_TIMER; a salir or timeout exit SHALL leave the flag unchanged.
REQ-021 SHALL clear flag_mostrar_count whenever fin_timer is high, and on a btn_salir event while in IDLE; clear SHALL win over a simultaneous set.
REQ-022 SHALL change every output on the clock edge that samples the event, i.e. one cycle latency from the input going high.

Reset
REQ-023 SHALL, while reset is high, force state IDLE, funcion_conf=000, flag_mostrar_count=0, pulso_guardar=0, and the inactivity counter to 0, independent of clk.
REQ-024 SHALL load the button edge registers with 1 on reset, so a button held through reset release produces no event.
REQ-025 SHALL abandon any CONF state when reset is asserted mid-operation, with no commit pulse.

Verification
REQ-026 SHALL pass this case: reset, then a btn_fecha pulse followed by a btn_ok pulse -> funcion_conf 000->010->000, with pulso_guardar=1 for one cycle at exit.
REQ-027 SHALL pass this case: btn_hora and btn_timer rising in the same cycle from IDLE -> funcion_conf=001.
REQ-028 SHALL pass this case: btn_timer, then btn_ok, then fin_timer high 20 cycles later -> funcion_conf=100 then 000; flag_mostrar_count=1, clearing to 0 one cycle after fin_timer.
REQ-029 SHALL pass this case: with TIMEOUT_CYC=16, enter CONF_HORA with no further events -> funcion_conf returns to 000 at cycle 16 after entry, with pulso_guardar remaining 0.
REQ-030 SHALL pass this case: with TIMEOUT_CYC=16, in CONF_FECHA a btn_hora event at cycle 10 -> state unchanged and the timeout extended to cycle 26.
REQ-031 SHALL pass this case: btn_hora held high across reset deassertion -> funcion_conf stays 000 until btn_hora falls and rises again.

Source files
------------

// File: rtl/control_funcion_conf.sv
// Configuration-mode controller: selects which register bank the buttons edit,
// issues the commit strobe and manages the countdown-display flag.
module control_funcion_conf #(
    parameter int unsigned TIMEOUT_CYC = 500_000_000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       btn_hora,
    input  logic       btn_fecha,
    input  logic       btn_timer,
    input  logic       btn_ok,
    input  logic       btn_salir,
    input  logic       fin_timer,
    output logic [2:0] funcion_conf,
    output logic       flag_mostrar_count,
    output logic       pulso_guardar
);

    typedef enum logic [2:0] {
        IDLE       = 3'b000,
        CONF_HORA  = 3'b001,
        CONF_FECHA = 3'b010,
        CONF_TIMER = 3'b100
    } state_t;

    localparam logic [28:0] CNT_LAST = 29'(TIMEOUT_CYC - 1);

    state_t      state_q, state_n;
    logic [28:0] cnt_q, cnt_n;
    logic        flag_q, flag_n;
    logic        pulso_q, pulso_n;

    logic hora_q, fecha_q, timer_q, ok_q, salir_q;
    logic ev_hora, ev_fecha, ev_timer, ev_ok, ev_salir, ev_any;

    assign ev_hora  = btn_hora  & ~hora_q;
    assign ev_fecha = btn_fecha & ~fecha_q;
    assign ev_timer = btn_timer & ~timer_q;
    assign ev_ok    = btn_ok    & ~ok_q;
    assign ev_salir = btn_salir & ~salir_q;
    assign ev_any   = ev_hora | ev_fecha | ev_timer | ev_ok | ev_salir;

    // Edge registers reset high so a button held through reset is not an event.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hora_q  <= 1'b1;
            fecha_q <= 1'b1;
            timer_q <= 1'b1;
            ok_q    <= 1'b1;
            salir_q <= 1'b1;
        end else begin
            hora_q  <= btn_hora;
            fecha_q <= btn_fecha;
            timer_q <= btn_timer;
            ok_q    <= btn_ok;
            salir_q <= btn_salir;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            flag_q  <= 1'b0;
            pulso_q <= 1'b0;
        end else begin
            state_q <= state_n;
            cnt_q   <= cnt_n;
            flag_q  <= flag_n;
            pulso_q <= pulso_n;
        end
    end

    always_comb begin
        state_n = state_q;
        cnt_n   = cnt_q;
        flag_n  = flag_q;
        pulso_n = 1'b0;

        case (state_q)
            IDLE: begin
                cnt_n = '0;
                if (ev_hora)
                    state_n = CONF_HORA;
                else if (ev_fecha)
                    state_n = CONF_FECHA;
                else if (ev_timer)
                    state_n = CONF_TIMER;
                if (ev_salir)
                    flag_n = 1'b0;
            end
            CONF_HORA, CONF_FECHA, CONF_TIMER: begin
                if (ev_salir) begin
                    state_n = IDLE;
                    cnt_n   = '0;
                end else if (ev_ok) begin
                    state_n = IDLE;
                    cnt_n   = '0;
                    if (state_q == CONF_TIMER)
                        flag_n = 1'b1;
                    else
                        pulso_n = 1'b1;
                end else if (ev_any) begin
                    cnt_n = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_n = IDLE;
                    cnt_n   = '0;
                end else begin
                    cnt_n = cnt_q + 29'd1;
                end
            end
            default: begin
                state_n = IDLE;
                cnt_n   = '0;
            end
        endcase

        if (fin_timer)
            flag_n = 1'b0;
    end

    assign funcion_conf       = state_q;
    assign flag_mostrar_count = flag_q;
    assign pulso_guardar      = pulso_q;

endmodule
